// File: rtl/sy_pkg.sv
// ---------------------------------------------------------------------------
// sy_pkg
// Shared types for the D-cache request arbiter:
//   arb_src_e        requester identity (LSU / PTW)
//   dcache_req_t     request payload presented to the D-cache
//   dcache_rsp_t     response payload returned by the D-cache
//   arb_entry_t      in-flight tracking entry {src, kill}
//   DCACHE_ARB_OUTST default number of outstanding D-cache requests
// ---------------------------------------------------------------------------
package sy_pkg;

    localparam int unsigned DCACHE_ARB_OUTST = 4;

    typedef enum logic {
        ARB_SRC_LSU = 1'b0,
        ARB_SRC_PTW = 1'b1
    } arb_src_e;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dcache_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dcache_rsp_t;

    typedef struct packed {
        arb_src_e src;
        logic     kill;
    } arb_entry_t;

    function automatic arb_src_e other_src(input arb_src_e s);
        return (s == ARB_SRC_LSU) ? ARB_SRC_PTW : ARB_SRC_LSU;
    endfunction

endpackage

// File: rtl/sy_ppl_dcache_arb_fifo.sv
// ---------------------------------------------------------------------------
// sy_ppl_dcache_arb_fifo
// In-order tracker of requests outstanding at the D-cache. Each entry records
// which requester issued it and whether its response must be dropped.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   push_i/push_ent_i  enqueue an entry (caller guarantees not full)
//   pop_i              dequeue the head (caller guarantees not empty)
//   kill_vld_i/src_i   mark every entry of kill_src_i as killed, including
//                      one pushed and the head seen in this same cycle
//   head_o             head entry, with this cycle's kill already applied
//   full_o, empty_o    occupancy flags
// ---------------------------------------------------------------------------
module sy_ppl_dcache_arb_fifo
    import sy_pkg::*;
#(
    parameter int unsigned DEPTH = DCACHE_ARB_OUTST
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  arb_entry_t push_ent_i,
    input  logic       pop_i,
    input  logic       kill_vld_i,
    input  arb_src_e   kill_src_i,
    output arb_entry_t head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    arb_entry_t       mem_q [DEPTH];
    arb_entry_t       mem_d [DEPTH];

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        mem_d = mem_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (kill_vld_i && mem_q[i].src == kill_src_i) begin
                mem_d[i].kill = 1'b1;
            end
        end
        if (push_i) begin
            mem_d[wr_ptr_q]      = push_ent_i;
            mem_d[wr_ptr_q].kill = push_ent_i.kill
                                 | (kill_vld_i && push_ent_i.src == kill_src_i);
        end
        // Pointers are PTR_W bits wide, so they wrap modulo DEPTH for free.
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        cnt_d    = cnt_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
    end

    always_comb begin
        head_o      = mem_q[rd_ptr_q];
        head_o.kill = mem_q[rd_ptr_q].kill
                    | (kill_vld_i && mem_q[rd_ptr_q].src == kill_src_i);
    end

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: entry storage is not reset; cnt_q alone defines which entries are
    // live, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sy_ppl_dcache_arb.sv
// ---------------------------------------------------------------------------
// sy_ppl_dcache_arb
// Round-robin arbiter between the LSU and the PTW for a single D-cache port,
// with grant/payload hold while the cache stalls, in-order response routing,
// flush-based dropping of LSU responses and a sticky protocol error flag.
// Ports:
//   clk_i, rst_i                         clock, async active-high reset
//   flush_i                              pipeline flush (kills LSU traffic)
//   lsu_arb__* / arb_lsu__rdy_o          LSU request channel
//   ptw_arb__* / arb_ptw__rdy_o          PTW request channel
//   arb_dcache__* / dcache_arb__rdy_i    request channel to the D-cache
//   dcache_arb__rsp_*                    in-order responses from the D-cache
//   arb_lsu__rsp_vld_o, arb_ptw__rsp_vld_o, arb_rsp_o  routed response
//   arb__idle_o                          nothing in flight
//   arb__err_o                           response seen with nothing in flight
// ---------------------------------------------------------------------------
module sy_ppl_dcache_arb
    import sy_pkg::*;
#(
    parameter int unsigned OUTST_DEPTH = DCACHE_ARB_OUTST
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        lsu_arb__vld_i,
    output logic        arb_lsu__rdy_o,
    input  dcache_req_t lsu_arb__req_i,
    input  logic        ptw_arb__vld_i,
    output logic        arb_ptw__rdy_o,
    input  dcache_req_t ptw_arb__req_i,
    output logic        arb_dcache__vld_o,
    input  logic        dcache_arb__rdy_i,
    output dcache_req_t arb_dcache__req_o,
    input  logic        dcache_arb__rsp_vld_i,
    input  dcache_rsp_t dcache_arb__rsp_i,
    output logic        arb_lsu__rsp_vld_o,
    output logic        arb_ptw__rsp_vld_o,
    output dcache_rsp_t arb_rsp_o,
    output logic        arb__idle_o,
    output logic        arb__err_o
);

    arb_src_e    ptr_q, ptr_d;
    logic        hold_vld_q, hold_vld_d;
    arb_src_e    hold_src_q, hold_src_d;
    dcache_req_t hold_req_q, hold_req_d;
    logic        err_q, err_d;

    logic        hold_act;
    arb_src_e    gnt_src;
    logic        gnt_vld;
    dcache_req_t gnt_req;
    logic        issue, hs, pop, fwd;
    logic        fifo_full, fifo_empty;
    arb_entry_t  head;

    always_comb begin
        // A flush releases a stalled LSU grant in the same cycle.
        hold_act = hold_vld_q && !(flush_i && hold_src_q == ARB_SRC_LSU);

        if (hold_act)                              gnt_src = hold_src_q;
        else if (lsu_arb__vld_i && ptw_arb__vld_i) gnt_src = ptr_q;
        else if (ptw_arb__vld_i)                   gnt_src = ARB_SRC_PTW;
        else                                       gnt_src = ARB_SRC_LSU;

        gnt_vld = (gnt_src == ARB_SRC_LSU) ? lsu_arb__vld_i : ptw_arb__vld_i;
        gnt_req = hold_act ? hold_req_q
                : (gnt_src == ARB_SRC_LSU) ? lsu_arb__req_i : ptw_arb__req_i;

        // Full is taken from registered occupancy: a pop this cycle does not
        // open a slot until the next one.
        issue = gnt_vld && !fifo_full && !rst_i;
        hs    = issue && dcache_arb__rdy_i;
        pop   = dcache_arb__rsp_vld_i && !fifo_empty;
        fwd   = pop && !head.kill;

        hold_vld_d = hold_vld_q;
        hold_src_d = hold_src_q;
        hold_req_d = hold_req_q;
        if (hold_act) begin
            hold_vld_d = !hs;
        end else begin
            hold_vld_d = issue && !hs;
            hold_src_d = gnt_src;
            hold_req_d = gnt_req;
        end

        ptr_d = hs ? other_src(gnt_src) : ptr_q;
        err_d = err_q | (dcache_arb__rsp_vld_i && fifo_empty);
    end

    sy_ppl_dcache_arb_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (hs),
        .push_ent_i ('{src: gnt_src, kill: 1'b0}),
        .pop_i      (pop),
        .kill_vld_i (flush_i),
        .kill_src_i (ARB_SRC_LSU),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign arb_dcache__vld_o  = issue;
    assign arb_dcache__req_o  = issue ? gnt_req : '0;
    assign arb_lsu__rdy_o     = !rst_i && gnt_src == ARB_SRC_LSU && dcache_arb__rdy_i && !fifo_full;
    assign arb_ptw__rdy_o     = !rst_i && gnt_src == ARB_SRC_PTW && dcache_arb__rdy_i && !fifo_full;
    assign arb_lsu__rsp_vld_o = fwd && head.src == ARB_SRC_LSU;
    assign arb_ptw__rsp_vld_o = fwd && head.src == ARB_SRC_PTW;
    assign arb_rsp_o          = fwd ? dcache_arb__rsp_i : '0;
    assign arb__idle_o        = fifo_empty;
    assign arb__err_o         = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q      <= ARB_SRC_LSU;
            hold_vld_q <= 1'b0;
            hold_src_q <= ARB_SRC_LSU;
            hold_req_q <= '0;
            err_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            hold_vld_q <= hold_vld_d;
            hold_src_q <= hold_src_d;
            hold_req_q <= hold_req_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_sy_ppl_dcache_arb.sv
// ---------------------------------------------------------------------------
// tb_sy_ppl_dcache_arb
// Drives directed and random traffic into sy_ppl_dcache_arb. A behavioural
// model (queue of in-flight requests, round-robin pointer, stall hold) sets
// the expected combinational outputs each cycle; expected responses go into
// a scoreboard queue that an independent monitor drains.
// ---------------------------------------------------------------------------
module tb_sy_ppl_dcache_arb;
    import sy_pkg::*;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        lsu_arb__vld_i = 1'b0, ptw_arb__vld_i = 1'b0;
    logic        arb_lsu__rdy_o, arb_ptw__rdy_o;
    dcache_req_t lsu_arb__req_i = '0, ptw_arb__req_i = '0;
    logic        arb_dcache__vld_o;
    logic        dcache_arb__rdy_i = 1'b0;
    dcache_req_t arb_dcache__req_o;
    logic        dcache_arb__rsp_vld_i = 1'b0;
    dcache_rsp_t dcache_arb__rsp_i = '0;
    logic        arb_lsu__rsp_vld_o, arb_ptw__rsp_vld_o;
    dcache_rsp_t arb_rsp_o;
    logic        arb__idle_o, arb__err_o;

    sy_ppl_dcache_arb #(.OUTST_DEPTH(DEPTH)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .flush_i               (flush_i),
        .lsu_arb__vld_i        (lsu_arb__vld_i),
        .arb_lsu__rdy_o        (arb_lsu__rdy_o),
        .lsu_arb__req_i        (lsu_arb__req_i),
        .ptw_arb__vld_i        (ptw_arb__vld_i),
        .arb_ptw__rdy_o        (arb_ptw__rdy_o),
        .ptw_arb__req_i        (ptw_arb__req_i),
        .arb_dcache__vld_o     (arb_dcache__vld_o),
        .dcache_arb__rdy_i     (dcache_arb__rdy_i),
        .arb_dcache__req_o     (arb_dcache__req_o),
        .dcache_arb__rsp_vld_i (dcache_arb__rsp_vld_i),
        .dcache_arb__rsp_i     (dcache_arb__rsp_i),
        .arb_lsu__rsp_vld_o    (arb_lsu__rsp_vld_o),
        .arb_ptw__rsp_vld_o    (arb_ptw__rsp_vld_o),
        .arb_rsp_o             (arb_rsp_o),
        .arb__idle_o           (arb__idle_o),
        .arb__err_o            (arb__err_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: src 0 = LSU, 1 = PTW.
    typedef struct { bit src; bit kill; } ent_t;
    typedef struct { bit src; dcache_rsp_t rsp; } exp_rsp_t;

    ent_t        inflight[$];
    exp_rsp_t    exp_q[$];
    bit          m_ptr, m_hold, m_hold_src, m_err;
    dcache_req_t m_hold_req;
    bit          pend_l, pend_p;

    function automatic dcache_req_t rand_req();
        dcache_req_t r;
        r.addr  = 16'($urandom);
        r.we    = 1'($urandom);
        r.wdata = $urandom;
        r.be    = 4'($urandom);
        return r;
    endfunction

    // One clock cycle: drive after the rising edge, check on the falling edge,
    // then advance the model to what the next rising edge commits.
    task automatic cycle(input bit want_l, input bit want_p, input bit rdy,
                         input bit flush, input bit rsp, input bit allow_empty = 1'b0);
        bit l, p, hold_eff, gnt, gv, full, vld, hs, pop, fwd, rsp_eff;
        dcache_req_t ereq;
        dcache_rsp_t r;
        ent_t h;
        @(posedge clk_i);
        #1;
        l = want_l | pend_l;
        p = want_p | pend_p;
        if (!pend_l) lsu_arb__req_i = rand_req();
        if (!pend_p) ptw_arb__req_i = rand_req();
        rsp_eff = rsp && (allow_empty || inflight.size() > 0);
        r.rdata = $urandom;
        r.err   = 1'($urandom);
        lsu_arb__vld_i        = l;
        ptw_arb__vld_i        = p;
        dcache_arb__rdy_i     = rdy;
        flush_i               = flush;
        dcache_arb__rsp_vld_i = rsp_eff;
        dcache_arb__rsp_i     = r;

        hold_eff = m_hold && !(flush && !m_hold_src);
        gnt  = hold_eff ? m_hold_src : (l && p) ? m_ptr : p;
        gv   = gnt ? p : l;
        full = (inflight.size() == DEPTH);
        vld  = gv && !full;
        hs   = vld && rdy;
        ereq = !vld ? '0 : hold_eff ? m_hold_req : (gnt ? ptw_arb__req_i : lsu_arb__req_i);
        pop  = rsp_eff && inflight.size() > 0;
        fwd  = 1'b0;
        h    = '{src: 1'b0, kill: 1'b0};
        if (pop) begin
            h   = inflight[0];
            fwd = !(h.kill || (flush && !h.src));
            if (fwd) exp_q.push_back('{src: h.src, rsp: r});
        end

        @(negedge clk_i);
        check("dcache_vld", 64'(arb_dcache__vld_o), 64'(vld));
        check("dcache_req", 64'(arb_dcache__req_o), 64'(ereq));
        check("lsu_rdy", 64'(arb_lsu__rdy_o), 64'(!gnt && rdy && !full));
        check("ptw_rdy", 64'(arb_ptw__rdy_o), 64'(gnt && rdy && !full));
        check("lsu_rsp_vld", 64'(arb_lsu__rsp_vld_o), 64'(fwd && !h.src));
        check("ptw_rsp_vld", 64'(arb_ptw__rsp_vld_o), 64'(fwd && h.src));
        check("idle", 64'(arb__idle_o), 64'(inflight.size() == 0));
        check("err", 64'(arb__err_o), 64'(m_err));

        if (flush) foreach (inflight[i]) if (!inflight[i].src) inflight[i].kill = 1'b1;
        if (pop) void'(inflight.pop_front());
        if (hs) inflight.push_back('{src: gnt, kill: flush && !gnt});
        if (hold_eff) begin
            m_hold = !hs;
        end else begin
            m_hold     = vld && !hs;
            m_hold_src = gnt;
            m_hold_req = ereq;
        end
        if (hs) m_ptr = !gnt;
        if (rsp_eff && inflight.size() == 0 && !pop) m_err = 1'b1;
        pend_l = l && !(hs && !gnt);
        pend_p = p && !(hs && gnt);
    endtask

    // Asynchronous reset pulse between edges, with active requests on the
    // inputs, so the output gating during reset is observed.
    task automatic do_reset();
        @(posedge clk_i);
        #2;
        lsu_arb__vld_i    = 1'b1;
        ptw_arb__vld_i    = 1'b1;
        dcache_arb__rdy_i = 1'b1;
        rst_i             = 1'b1;
        #1;
        check("rst_dcache_vld", 64'(arb_dcache__vld_o), 64'd0);
        check("rst_dcache_req", 64'(arb_dcache__req_o), 64'd0);
        check("rst_lsu_rdy", 64'(arb_lsu__rdy_o), 64'd0);
        check("rst_ptw_rdy", 64'(arb_ptw__rdy_o), 64'd0);
        check("rst_rsp_vld", 64'({arb_lsu__rsp_vld_o, arb_ptw__rsp_vld_o}), 64'd0);
        check("rst_rsp", 64'(arb_rsp_o), 64'd0);
        check("rst_idle", 64'(arb__idle_o), 64'd1);
        check("rst_err", 64'(arb__err_o), 64'd0);
        @(negedge clk_i);
        lsu_arb__vld_i        = 1'b0;
        ptw_arb__vld_i        = 1'b0;
        dcache_arb__rdy_i     = 1'b0;
        dcache_arb__rsp_vld_i = 1'b0;
        flush_i               = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        inflight.delete();
        exp_q.delete();
        m_ptr  = 1'b0;
        m_hold = 1'b0;
        m_err  = 1'b0;
        pend_l = 1'b0;
        pend_p = 1'b0;
    endtask

    // Response monitor: pops the scoreboard whenever a response is routed.
    initial begin : monitor
        exp_rsp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && (arb_lsu__rsp_vld_o || arb_ptw__rsp_vld_o)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got lsu=%0b ptw=%0b expected none at %0t",
                             arb_lsu__rsp_vld_o, arb_ptw__rsp_vld_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_route_ptw", 64'(arb_ptw__rsp_vld_o), 64'(e.src));
                    check("rsp_payload", 64'(arb_rsp_o), 64'(e.rsp));
                end
            end
        end
    end

    initial begin
        do_reset();

        // Both requesters always valid: grants alternate, responses one cycle later.
        for (int i = 0; i < 8; i++) cycle(1, 1, 1, 0, i > 0);
        repeat (4) cycle(0, 0, 1, 0, 1);

        // Stall with LSU granted; PTW joins while stalled.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        repeat (3) cycle(0, 0, 1, 0, 1);

        // Fill to depth, then a pop must not let the fifth request bypass full.
        repeat (4) cycle(1, 0, 1, 0, 0);
        cycle(1, 0, 1, 0, 0);
        cycle(1, 0, 1, 0, 1);
        cycle(1, 0, 1, 0, 0);
        repeat (5) cycle(0, 0, 1, 0, 1);

        // LSU, PTW, LSU in flight, flush: only the PTW response survives.
        cycle(1, 0, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(1, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);
        repeat (3) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);

        // Flush while the LSU is stalled with a grant hold.
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 1, 0);
        cycle(1, 1, 1, 0, 0);
        repeat (4) cycle(0, 0, 1, 0, 1);

        // Response with nothing in flight: sticky error, cleared by reset.
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0);
        check("err_sticky", 64'(arb__err_o), 64'd1);
        do_reset();

        // Reset mid-transaction discards in-flight entries.
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        do_reset();
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) == 0);
        end
        repeat (20) cycle(0, 0, 1, 0, 1);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("final_idle", 64'(arb__idle_o), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
